// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - pending data-request buffer with overflow and head-age watchdog
module mem_request_unit #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     ihit,
    input  logic                     dhit,
    input  logic                     dMemRe,
    input  logic                     dMemWr,
    input  logic [AW-1:0]            daddr_in,
    input  logic [DW-1:0]            dstore_in,
    input  logic                     flush,
    output logic                     imemREN,
    output logic                     dmemREN,
    output logic                     dmemWEN,
    output logic [AW-1:0]            dmemaddr,
    output logic [DW-1:0]            dmemstore,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     full,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int PW  = $clog2(DEPTH);
    localparam int AGW = $clog2(TIMEOUT + 1);
    localparam logic [PW:0]    DEPTH_C   = (PW + 1)'(DEPTH);
    localparam logic [AGW-1:0] TIMEOUT_C = AGW'(TIMEOUT);

    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;
    logic [PW:0]    count_next;
    logic [AGW-1:0] age;

    logic           type_mem [DEPTH];
    logic [AW-1:0]  addr_mem [DEPTH];
    logic [DW-1:0]  data_mem [DEPTH];

    logic push_req;
    logic do_pop;
    logic do_push;
    logic drop;
    logic has_head;

    assign has_head = (count != '0);
    assign push_req = ihit && (dMemRe || dMemWr);
    assign do_pop   = dhit && has_head && !flush;
    // A full buffer still accepts a push when the head leaves on the same edge.
    assign do_push  = push_req && !flush && ((count != DEPTH_C) || do_pop);
    assign drop     = push_req && !flush && (count == DEPTH_C) && !do_pop;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else
            count_next = count + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            type_mem[wr_ptr] <= dMemWr;
            addr_mem[wr_ptr] <= daddr_in;
            data_mem[wr_ptr] <= dstore_in;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            age         <= '0;
            imemREN     <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            count   <= count_next;
            imemREN <= (count_next != DEPTH_C);
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (do_pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (do_push)
                    wr_ptr <= wr_ptr + PW'(1);
            end
            if (drop)
                overflow <= 1'b1;
            if (age == TIMEOUT_C)
                timeout_err <= 1'b1;
            // Age tracks how long the current head has waited; it restarts per head.
            if (flush || do_pop || !has_head)
                age <= '0;
            else if (age != TIMEOUT_C)
                age <= age + AGW'(1);
        end
    end

    assign pending   = count;
    assign full      = (count == DEPTH_C);
    assign dmemREN   = has_head && !type_mem[rd_ptr];
    assign dmemWEN   = has_head &&  type_mem[rd_ptr];
    assign dmemaddr  = has_head ? addr_mem[rd_ptr] : '0;
    assign dmemstore = has_head ? data_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - directed and randomized bench for mem_request_unit
module tb_mem_request_unit;

    localparam int DEPTH   = 4;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          ihit, dhit, dMemRe, dMemWr, flush;
    logic [AW-1:0] daddr_in;
    logic [DW-1:0] dstore_in;
    logic          imemREN, dmemREN, dmemWEN, full, overflow, timeout_err;
    logic [AW-1:0] dmemaddr;
    logic [DW-1:0] dmemstore;
    logic [$clog2(DEPTH):0] pending;

    always #5 CLK = ~CLK;

    mem_request_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dMemRe(dMemRe), .dMemWr(dMemWr),
        .daddr_in(daddr_in), .dstore_in(dstore_in), .flush(flush),
        .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .pending(pending), .full(full), .overflow(overflow),
        .timeout_err(timeout_err)
    );

    typedef struct {
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    req_t q[$];
    int   age;
    bit   m_ovf, m_terr, m_imem;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        age    = 0;
        m_ovf  = 0;
        m_terr = 0;
        m_imem = 0;
    endtask

    // Reference behaviour of one clock edge, using the inputs held across it.
    task automatic model_edge();
        bit   push, pop;
        req_t r;
        push = ihit && (dMemRe || dMemWr);
        pop  = dhit && (q.size() > 0);
        if (age == TIMEOUT) m_terr = 1;
        if (flush || pop || q.size() == 0) age = 0;
        else if (age < TIMEOUT) age++;
        if (flush) begin
            q.delete();
        end else if (push && q.size() == DEPTH && !pop) begin
            m_ovf = 1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                r.wr = dMemWr;
                r.a  = daddr_in;
                r.d  = dstore_in;
                q.push_back(r);
            end
        end
        m_imem = (q.size() != DEPTH);
    endtask

    task automatic check_all(input string tag);
        bit          h;
        logic [31:0] ea, ed;
        bit          er, ew;
        h  = (q.size() > 0);
        er = h && !q[0].wr;
        ew = h &&  q[0].wr;
        ea = h ? q[0].a : 32'h0;
        ed = h ? q[0].d : 32'h0;
        chk({tag, ".imemREN"},     64'(imemREN),     64'(m_imem));
        chk({tag, ".dmemREN"},     64'(dmemREN),     64'(er));
        chk({tag, ".dmemWEN"},     64'(dmemWEN),     64'(ew));
        chk({tag, ".dmemaddr"},    64'(dmemaddr),    64'(ea));
        chk({tag, ".dmemstore"},   64'(dmemstore),   64'(ed));
        chk({tag, ".pending"},     64'(pending),     64'(q.size()));
        chk({tag, ".full"},        64'(full),        64'(q.size() == DEPTH));
        chk({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
        chk({tag, ".timeout_err"}, 64'(timeout_err), 64'(m_terr));
    endtask

    task automatic step(input string tag, input bit ih, input bit dh, input bit re, input bit wr,
                        input bit fl, input logic [31:0] a, input logic [31:0] d);
        ihit = ih; dhit = dh; dMemRe = re; dMemWr = wr; flush = fl;
        daddr_in = a; dstore_in = d;
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic apply_reset(input string tag);
        nRST = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        ihit = 0; dhit = 0; dMemRe = 0; dMemWr = 0; flush = 0;
        @(posedge CLK);
        #1;
        check_all({tag, ".held"});
        nRST = 1'b1;
    endtask

    initial begin
        ihit = 0; dhit = 0; dMemRe = 0; dMemWr = 0; flush = 0;
        daddr_in = '0; dstore_in = '0;
        nRST = 1'b0;
        model_reset();
        #3;
        check_all("por");
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Reset release
        idle("release");
        chk("release.imem_one", 64'(imemREN), 64'd1);
        chk("release.pending_zero", 64'(pending), 64'd0);

        // Single read
        step("rd.push", 1, 0, 1, 0, 0, 32'h100, 32'h0);
        chk("rd.ren", 64'(dmemREN), 64'd1);
        chk("rd.addr", 64'(dmemaddr), 64'h100);
        step("rd.pop", 0, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("rd.ren_off", 64'(dmemREN), 64'd0);
        chk("rd.pending_off", 64'(pending), 64'd0);

        // Fill to full, overflow, push+pop when full, ordered drain
        for (int i = 0; i < 4; i++)
            step("fill", 1, 0, 0, 1, 0, 32'h200 + 32'(i * 4), $urandom);
        chk("fill.full", 64'(full), 64'd1);
        chk("fill.imem_off", 64'(imemREN), 64'd0);
        step("ovf.push", 1, 0, 0, 1, 0, 32'hDEAD, 32'hBEEF);
        chk("ovf.flag", 64'(overflow), 64'd1);
        chk("ovf.pending", 64'(pending), 64'd4);
        step("fullpp", 1, 1, 0, 1, 0, 32'h300, $urandom);
        chk("fullpp.pending", 64'(pending), 64'd4);
        chk("fullpp.head", 64'(dmemaddr), 64'h204);
        for (int i = 0; i < 4; i++)
            step("drain", 0, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("drain.empty", 64'(pending), 64'd0);

        // Both-type and pointer wrap
        step("both.push", 1, 0, 1, 1, 0, 32'h400, 32'h55AA);
        chk("both.wen", 64'(dmemWEN), 64'd1);
        chk("both.ren", 64'(dmemREN), 64'd0);
        step("both.pop", 0, 1, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step("wrap.push", 1, 0, 1, 0, 0, $urandom, $urandom);
            step("wrap.pop", 0, 1, 0, 0, 0, 32'h0, 32'h0);
        end

        // Watchdog then flush
        apply_reset("rst2");
        step("wd.push", 1, 0, 1, 0, 0, 32'h500, 32'h0);
        for (int i = 0; i < 8; i++)
            idle("wd.wait");
        chk("wd.not_yet", 64'(timeout_err), 64'd0);
        idle("wd.wait");
        chk("wd.terr", 64'(timeout_err), 64'd1);
        chk("wd.ren_held", 64'(dmemREN), 64'd1);
        step("wd.flush", 0, 0, 0, 0, 1, 32'h0, 32'h0);
        chk("wd.flush_pending", 64'(pending), 64'd0);
        chk("wd.terr_sticky", 64'(timeout_err), 64'd1);

        // Randomized traffic
        apply_reset("rst3");
        for (int i = 0; i < 600; i++) begin
            bit dh;
            dh = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step("rand", 1'($urandom_range(0, 1)), dh, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), $urandom, $urandom);
        end

        // Asynchronous reset mid-operation
        apply_reset("rst4");
        step("mid.push", 1, 0, 1, 0, 0, 32'h600, 32'h0);
        step("mid.push", 1, 0, 0, 1, 0, 32'h604, 32'h1);
        step("mid.push", 1, 0, 1, 0, 0, 32'h608, 32'h2);
        ihit = 0; dMemRe = 0; dMemWr = 0;
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        check_all("mid.async");
        chk("mid.ren", 64'(dmemREN), 64'd0);
        chk("mid.wen", 64'(dmemWEN), 64'd0);
        chk("mid.pending", 64'(pending), 64'd0);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        idle("mid.release");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
